pipeline_ctrl: RTL



---
 rtl/pipeline_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Sequencing controller for the five-stage pipeline register bank
// (IF/ID, ID/EX, EX/MEM, MEM/WB). Every cycle it decides which stage
// registers load, which are cleared to a bubble, and whether the PC advances.
// It resolves instruction/data memory waits, load-use hazards, redirects
// resolved in MEM, and halt. It also gates the cache request lines so that a
// data access that has already completed is never issued a second time.
//
// Optional feature macro: PIPE_CTRL_PERF_EN
//   When defined, adds the 32-bit performance counters stall_cnt and
//   flush_cnt. When undefined, those ports and counters do not exist and
//   behaviour is otherwise identical.
//
// Parameters:
//   REG_W         register-specifier width (default 5)
//
// Ports:
//   CLK           in   system clock, rising edge
//   RST           in   synchronous active-high reset; forces every output to 0
//   ihit          in   instruction fetch completes this cycle
//   dhit          in   data access completes this cycle
//   mem_dren      in   MEM-stage instruction is a load
//   mem_dwen      in   MEM-stage instruction is a store
//   mem_redirect  in   MEM-stage branch taken / jump / jr / jal
//   ex_memtoreg   in   EX-stage instruction is a load
//   ex_rt         in   EX-stage load destination register
//   id_rs, id_rt  in   ID-stage source registers
//   wb_halt       in   WB-stage instruction is halt
//   pc_en         out  PC loads its next value
//   ifid_en, idex_en, exmem_en, memwb_en   out  stage register loads
//   ifid_flush, idex_flush, exmem_flush    out  stage register clears (wins
//                                               over the matching enable)
//   iren          out  instruction read request
//   dren, dwen    out  data read / write request
//   halt          out  sticky processor-halted flag
//   stall_cnt     out  (PIPE_CTRL_PERF_EN only) stalled-cycle counter
//   flush_cnt     out  (PIPE_CTRL_PERF_EN only) advancing-redirect counter
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int REG_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dren,
   input  logic             mem_dwen,
   input  logic             mem_redirect,
   input  logic             ex_memtoreg,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             iren,
   output logic             dren,
   output logic             dwen,
   output logic             halt
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      flush_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,   // no data access outstanding
      ST_DWAIT = 2'd1,   // MEM holds a load/store that has not completed
      ST_DDONE = 2'd2,   // data served, waiting for ihit to advance
      ST_HALT  = 2'd3    // stopped until reset
   } state_t;

   state_t state_q;
   state_t state_d;

   logic memop;
   logic mem_ok;
   logic not_halt;
   logic adv;
   logic load_use;
   logic go;

   // ---------------------------------------------------------------------------
   // Hazard and advance decision
   // ---------------------------------------------------------------------------
   always_comb begin
      memop    = mem_dren | mem_dwen;
      not_halt = (state_q != ST_HALT);
      // Once the data side is served (DDONE) the MEM access no longer blocks.
      mem_ok   = !memop | dhit | (state_q == ST_DDONE);
      adv      = ihit & mem_ok & not_halt;
      // Register 0 is hardwired, so a load to it never creates a dependency.
      load_use = ex_memtoreg & (ex_rt != '0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));
      // A halt reaching WB beats an advance in the same cycle, and reset
      // freezes everything.
      go       = adv & !wb_halt & !RST;
   end

   // ---------------------------------------------------------------------------
   // Stage enables, flushes and PC enable
   // ---------------------------------------------------------------------------
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;

      if (go) begin
         if (mem_redirect) begin
            // Squash the three younger instructions; this outranks load-use
            // because the stalled instruction is on the wrong path anyway.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX, let the load
            // continue down the pipe.
            idex_en     = 1'b1;
            idex_flush  = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
         end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Memory requests and halt flag
   // ---------------------------------------------------------------------------
   always_comb begin
      iren = not_halt & !RST;
      // In DDONE the access has already completed; dropping the request here
      // keeps the cache from performing it a second time.
      dren = mem_dren & (state_q != ST_DDONE) & not_halt & !RST;
      dwen = mem_dwen & (state_q != ST_DDONE) & not_halt & !RST;
      halt = (state_q == ST_HALT) & !RST;
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (wb_halt || (state_q == ST_HALT)) begin
         state_d = ST_HALT;
      end else if ((state_q == ST_RUN) && memop && !dhit) begin
         state_d = ST_DWAIT;
      end else if (((state_q == ST_RUN) || (state_q == ST_DWAIT)) &&
                   memop && dhit && !ihit) begin
         state_d = ST_DDONE;
      end else if (adv) begin
         // Includes dhit and ihit together: advance straight back to RUN.
         state_d = ST_RUN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;
   logic [31:0] flush_cnt_q;
   logic [31:0] flush_cnt_d;
   logic        stall_inc;
   logic        flush_inc;

   always_comb begin
      // A stall is any live cycle where the PC does not move forward on the
      // normal path: a full freeze or a load-use hold. Counters stop in HALT.
      stall_inc   = not_halt & (!go | (!mem_redirect & load_use));
      flush_inc   = go & mem_redirect;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc) begin
         stall_cnt_d = stall_cnt_q + 32'd1;   // wraps naturally at 2^32
      end
      if (flush_inc) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
